mem_io_bridge: RTL and testbench

- Parametrised memory/IO steering block between the CPU datapath, data memory and N memory-mapped IO channels.
- Decodes IO addresses into one-hot channel selects and steers write and read-back data.
- Runs IO accesses through a request/acknowledge handshake and stalls the CPU until each access completes, times out or misses the IO window.
- Memory accesses pass straight through with no added latency.

---
 rtl/mem_io_bridge_if.sv | 14 +
 rtl/mem_io_bridge.sv | 161 ++++++++++++++++
 tb/tb_mem_io_bridge.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_io_bridge_if.sv
// IO channel bus between mem_io_bridge (master) and the memory-mapped IO channels (slave).
interface mem_io_bridge_if #(
  parameter int IO_CH   = 4,
  parameter int IO_RD_W = 16
);
  logic [IO_CH-1:0]         io_sel;
  logic                     io_we;
  logic                     io_re;
  logic [IO_CH*IO_RD_W-1:0] io_rdata;
  logic [IO_CH-1:0]         io_ack;

  modport master (output io_sel, io_we, io_re, input io_rdata, io_ack);
  modport slave  (input io_sel, io_we, io_re, output io_rdata, io_ack);
endinterface

// File: rtl/mem_io_bridge.sv
// Memory/IO steering bridge: memory pass-through plus stalled req/ack IO channel accesses.
// Define IO_TIMEOUT_EN to abort IO accesses that see no ack within TIMEOUT WAIT cycles.
//
// state  | meaning
// S_IDLE | memory pass-through, decode and accept IO requests
// S_WAIT | channel selected, CPU stalled until matching ack (or timeout)
// S_DONE | one-cycle completion, read-back data presented, CPU released
module mem_io_bridge #(
  parameter int          DATA_W    = 32,
  parameter int          IO_CH     = 4,
  parameter logic [31:0] IO_BASE   = 32'hFFFF_F000,
  parameter int          IO_STRIDE = 16,
  parameter int          IO_RD_W   = 16,
  parameter int          TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mRead,
  input  logic              mWrite,
  input  logic              ioRead,
  input  logic              ioWrite,
  input  logic [31:0]       addr_in,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [DATA_W-1:0] r_rdata,
  output logic [DATA_W-1:0] r_wdata,
  output logic              r_wvalid,
  output logic [DATA_W-1:0] write_data,
  output logic              stall,
  output logic              bus_err,
  mem_io_bridge_if.master   io
);

  localparam int          CH_W       = (IO_CH > 1) ? $clog2(IO_CH) : 1;
  localparam int          SH         = $clog2(IO_STRIDE);
  localparam logic [31:0] IO_SPAN    = 32'(IO_CH * IO_STRIDE);
  localparam logic [31:0] ALIGN_MASK = 32'(IO_STRIDE - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t            state;
  logic [CH_W-1:0]   ch_q;
  logic              is_rd_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic [31:0]       offset;
  logic              hit;
  logic [CH_W-1:0]   ch;
  logic [IO_CH-1:0]  onehot;
  logic              mem_en;
  logic              io_req;
  logic              ack_hit;
  logic [DATA_W-1:0] rsel;

`ifdef IO_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] to_cnt;
`endif

  assign offset  = addr_in - IO_BASE;
  assign hit     = (addr_in >= IO_BASE) && (offset < IO_SPAN) && ((offset & ALIGN_MASK) == 32'd0);
  assign ch      = CH_W'(offset >> SH);
  assign onehot  = IO_CH'(1) << ch;
  assign mem_en  = mRead | mWrite;
  assign io_req  = (ioRead | ioWrite) & ~mem_en;
  assign ack_hit = io.io_ack[ch_q];

  always_comb begin
    rsel = '0;
    rsel[IO_RD_W-1:0] = io.io_rdata[ch_q*IO_RD_W +: IO_RD_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      io.io_sel <= '0;
      io.io_we  <= 1'b0;
      io.io_re  <= 1'b0;
      bus_err   <= 1'b0;
      r_wvalid  <= 1'b0;
      ch_q      <= '0;
      is_rd_q   <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
`ifdef IO_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      bus_err  <= 1'b0;
      r_wvalid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (io_req) begin
            if (hit) begin
              state     <= S_WAIT;
              ch_q      <= ch;
              is_rd_q   <= ioRead;
              wdata_q   <= r_rdata;
              io.io_sel <= onehot;
              // read wins when the CPU asserts both strobes
              io.io_re  <= ioRead;
              io.io_we  <= ioWrite & ~ioRead;
`ifdef IO_TIMEOUT_EN
              to_cnt    <= '0;
`endif
            end else begin
              bus_err <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (ack_hit) begin
            state     <= S_DONE;
            rdata_q   <= rsel;
            r_wvalid  <= is_rd_q;
            io.io_sel <= '0;
            io.io_we  <= 1'b0;
            io.io_re  <= 1'b0;
          end
`ifdef IO_TIMEOUT_EN
          else if (to_cnt == CNT_W'(TIMEOUT - 1)) begin
            state     <= S_DONE;
            rdata_q   <= '0;
            bus_err   <= 1'b1;
            io.io_sel <= '0;
            io.io_we  <= 1'b0;
            io.io_re  <= 1'b0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    r_wdata    = '0;
    write_data = '0;
    stall      = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_en) begin
          if (mRead)  r_wdata    = m_rdata;
          if (mWrite) write_data = r_rdata;
        end else if (io_req && hit) begin
          stall = 1'b1;
        end
      end
      S_WAIT: begin
        stall      = 1'b1;
        write_data = wdata_q;
      end
      S_DONE:  r_wdata = rdata_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Self-checking bench for mem_io_bridge: transaction-level model compared every cycle plus directed literals.
module tb_mem_io_bridge;
  localparam int          DATA_W    = 32;
  localparam int          IO_CH     = 4;
  localparam logic [31:0] IO_BASE   = 32'hFFFF_F000;
  localparam int          IO_STRIDE = 16;
  localparam int          IO_RD_W   = 16;
  localparam int          TIMEOUT   = 15;
`ifdef IO_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mRead = 0, mWrite = 0, ioRead = 0, ioWrite = 0;
  logic [31:0] addr_in = '0;
  logic [DATA_W-1:0] m_rdata = '0, r_rdata = '0;
  logic [DATA_W-1:0] r_wdata, write_data;
  logic r_wvalid, stall, bus_err;

  mem_io_bridge_if #(.IO_CH(IO_CH), .IO_RD_W(IO_RD_W)) bus ();

  mem_io_bridge #(
    .DATA_W(DATA_W), .IO_CH(IO_CH), .IO_BASE(IO_BASE),
    .IO_STRIDE(IO_STRIDE), .IO_RD_W(IO_RD_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .mRead(mRead), .mWrite(mWrite), .ioRead(ioRead), .ioWrite(ioWrite),
    .addr_in(addr_in), .m_rdata(m_rdata), .r_rdata(r_rdata), .r_wdata(r_wdata),
    .r_wvalid(r_wvalid), .write_data(write_data), .stall(stall), .bus_err(bus_err), .io(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;
  logic [3:0] ack_sched [0:64];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic bit hit_f(input logic [31:0] a);
    int unsigned off;
    if (a < IO_BASE) return 1'b0;
    off = a - IO_BASE;
    return (off < IO_CH * IO_STRIDE) && (off % IO_STRIDE == 0);
  endfunction

  function automatic int ch_f(input logic [31:0] a);
    return int'((a - IO_BASE) / IO_STRIDE);
  endfunction

  // transaction-level model: outstanding access, completion cycle, miss pulse
  bit m_busy, m_fin, m_miss, m_err, m_vld, m_rd;
  int m_ch, m_wait;
  logic [31:0] m_data, m_wd;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 0; m_fin <= 0; m_miss <= 0; m_err <= 0; m_vld <= 0; m_rd <= 0;
      m_ch <= 0; m_wait <= 0; m_data <= '0; m_wd <= '0;
    end else begin
      m_miss <= 0;
      if (m_fin) m_fin <= 0;
      else if (m_busy) begin
        if (bus.io_ack[m_ch]) begin
          m_busy <= 0; m_fin <= 1; m_err <= 0; m_vld <= m_rd;
          m_data <= 32'(bus.io_rdata[m_ch*IO_RD_W +: IO_RD_W]);
        end else if (TO_EN && (m_wait + 1 == TIMEOUT)) begin
          m_busy <= 0; m_fin <= 1; m_err <= 1; m_vld <= 0; m_data <= '0;
        end else m_wait <= m_wait + 1;
      end else if (!(mRead || mWrite) && (ioRead || ioWrite)) begin
        if (hit_f(addr_in)) begin
          m_busy <= 1; m_ch <= ch_f(addr_in); m_rd <= ioRead; m_wd <= r_rdata; m_wait <= 0;
        end else m_miss <= 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit idle, req;
      idle = !m_busy && !m_fin;
      req  = !(mRead || mWrite) && (ioRead || ioWrite);
      chk("m_io_sel", 32'(bus.io_sel), m_busy ? 32'(1 << m_ch) : 32'd0);
      chk("m_io_re", 32'(bus.io_re), 32'(m_busy && m_rd));
      chk("m_io_we", 32'(bus.io_we), 32'(m_busy && !m_rd));
      chk("m_stall", 32'(stall), 32'(m_busy || (idle && req && hit_f(addr_in))));
      chk("m_bus_err", 32'(bus_err), 32'(m_miss || (m_fin && m_err)));
      chk("m_r_wvalid", 32'(r_wvalid), 32'(m_fin && m_vld));
      chk("m_r_wdata", r_wdata, m_fin ? m_data : (idle && mRead) ? m_rdata : 32'd0);
      chk("m_write_data", write_data, m_busy ? m_wd : (idle && mWrite) ? r_rdata : 32'd0);
    end
  end

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    mRead = 0; mWrite = 0; ioRead = 0; ioWrite = 0; bus.io_ack = '0;
  endtask

  task automatic io_access(input string nm, input logic [31:0] a, input bit rd, input bit wr,
                           input logic [31:0] wd, input int stall_exp, input logic [3:0] sel_exp,
                           input logic [31:0] rdata_exp, input bit vld_exp, input bit err_exp);
    int n;
    bit done;
    n = 0; done = 0;
    addr_in = a; ioRead = rd; ioWrite = wr; r_rdata = wd; bus.io_ack = ack_sched[0];
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (stall) begin
        n++;
        if (c > 0) begin
          chk({nm, "_sel"}, 32'(bus.io_sel), 32'(sel_exp));
          chk({nm, "_re"}, 32'(bus.io_re), 32'(rd));
          chk({nm, "_we"}, 32'(bus.io_we), 32'(wr && !rd));
          if (wr && !rd) chk({nm, "_wdata"}, write_data, wd);
        end
      end else begin
        done = 1;
        chk({nm, "_done_rdata"}, r_wdata, rdata_exp);
        chk({nm, "_done_vld"}, 32'(r_wvalid), 32'(vld_exp));
        chk({nm, "_done_err"}, 32'(bus_err), 32'(err_exp));
        chk({nm, "_done_sel"}, 32'(bus.io_sel), 32'd0);
      end
      next_cyc();
      if (done) idle_inputs();
      else bus.io_ack = ack_sched[c+1];
    end
    if (!done) chk({nm, "_completion_bound"}, 32'd0, 32'd1);
    chk({nm, "_stall_cycles"}, 32'(n), 32'(stall_exp));
    foreach (ack_sched[i]) ack_sched[i] = '0;
    idle_inputs();
  endtask

  task automatic miss_access(input string nm, input logic [31:0] a);
    addr_in = a; ioRead = 1;
    @(negedge clk);
    chk({nm, "_stall"}, 32'(stall), 32'd0);
    chk({nm, "_rdata"}, r_wdata, 32'd0);
    chk({nm, "_err_pre"}, 32'(bus_err), 32'd0);
    next_cyc();
    ioRead = 0;
    @(negedge clk);
    chk({nm, "_err_pulse"}, 32'(bus_err), 32'd1);
    next_cyc();
    @(negedge clk);
    chk({nm, "_err_clear"}, 32'(bus_err), 32'd0);
    next_cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog at %0t: simulation did not finish", $time);
    $fatal(1);
  end

  initial begin
    foreach (ack_sched[i]) ack_sched[i] = '0;
    bus.io_ack = '0;
    bus.io_rdata = {16'h3333, 16'h2222, 16'hBEEF, 16'h0000};
    @(posedge clk); @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_r_wdata", r_wdata, 32'd0);
    chk("rst_sel", 32'(bus.io_sel), 32'd0);
    chk("rst_err", 32'(bus_err), 32'd0);
    chk("rst_vld", 32'(r_wvalid), 32'd0);
    next_cyc();
    rst = 0;
    chk_en = 1;
    next_cyc();

    ack_sched[1] = 4'b0010;
    io_access("rd_ch1", 32'hFFFF_F010, 1, 0, 32'h0, 2, 4'b0010, 32'h0000_BEEF, 1, 0);

    ack_sched[3] = 4'b0001;
    io_access("wr_ch0", 32'hFFFF_F000, 0, 1, 32'h0000_00A5, 4, 4'b0001, 32'h0000_0000, 0, 0);

    ack_sched[1] = 4'b1000; ack_sched[3] = 4'b0100;
    io_access("rd_ch2", 32'hFFFF_F020, 1, 0, 32'h0, 4, 4'b0100, 32'h0000_2222, 1, 0);

    ack_sched[2] = 4'b1000;
    io_access("rdwr_ch3", 32'hFFFF_F030, 1, 1, 32'hDEAD_0001, 3, 4'b1000, 32'h0000_3333, 1, 0);

    addr_in = 32'hFFFF_F010; ioRead = 1; mRead = 1; m_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("mem_rd_rdata", r_wdata, 32'h1234_5678);
    chk("mem_rd_stall", 32'(stall), 32'd0);
    next_cyc();
    mRead = 0; mWrite = 1; r_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("mem_rd_sel", 32'(bus.io_sel), 32'd0);
    chk("mem_rd_noerr", 32'(bus_err), 32'd0);
    chk("mem_wr_wdata", write_data, 32'hCAFE_F00D);
    next_cyc();
    idle_inputs();
    next_cyc();

    miss_access("miss_unaligned", 32'hFFFF_F004);
    miss_access("miss_window", 32'hFFFF_F040);
    miss_access("miss_below", 32'hFFFF_EFF0);

`ifdef IO_TIMEOUT_EN
    io_access("to_noack", 32'hFFFF_F010, 1, 0, 32'h0, 16, 4'b0010, 32'h0, 0, 1);
    ack_sched[15] = 4'b0010;
    io_access("to_ack_last", 32'hFFFF_F010, 1, 0, 32'h0, 16, 4'b0010, 32'h0000_BEEF, 1, 0);
`else
    ack_sched[20] = 4'b0001;
    io_access("long_wait", 32'hFFFF_F000, 1, 0, 32'h0, 21, 4'b0001, 32'h0000_0000, 1, 0);
`endif

    addr_in = 32'hFFFF_F020; ioRead = 1;
    repeat (6) next_cyc();
    @(negedge clk);
    chk("rstw_stall_pre", 32'(stall), 32'd1);
    next_cyc();
    rst = 1; ioRead = 0;
    next_cyc();
    rst = 0;
    @(negedge clk);
    chk("rstw_stall", 32'(stall), 32'd0);
    chk("rstw_sel", 32'(bus.io_sel), 32'd0);
    chk("rstw_re", 32'(bus.io_re), 32'd0);
    chk("rstw_err", 32'(bus_err), 32'd0);
    chk("rstw_vld", 32'(r_wvalid), 32'd0);
    chk("rstw_rdata", r_wdata, 32'd0);
    next_cyc();
    @(negedge clk);
    chk("rstw_err_after", 32'(bus_err), 32'd0);
    next_cyc();

    ack_sched[1] = 4'b0100;
    io_access("rd_after_rst", 32'hFFFF_F020, 1, 0, 32'h0, 2, 4'b0100, 32'h0000_2222, 1, 0);

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
